// File: rtl/merlin_mem_pkg.sv
// Shared types for the merlin32i memory responders.
package merlin_mem_pkg;

    typedef struct packed {
        logic        rerr;
        logic        werr;
        logic [31:0] data;
    } rsp_t;

    localparam int C_RSP_FIFO_DEPTH = 2;

endpackage

// File: rtl/data_ram_rsp_fifo.sv
// Small in-order response queue between the RAM access stage and the response port.
module data_ram_rsp_fifo
    import merlin_mem_pkg::*;
#(
    localparam int CW = $clog2(C_RSP_FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  rsp_t          din,
    output rsp_t          dout,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(C_RSP_FIFO_DEPTH);

    rsp_t          mem [C_RSP_FIFO_DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    assign dout = mem[rptr];

endmodule

// File: rtl/data_ram_target.sv
// Data-side RAM responder: one access stage feeding a 2-entry response FIFO,
// with the stage bypassing the FIFO when it is empty so a response appears the cycle after accept.
module data_ram_target
    import merlin_mem_pkg::*;
#(
    parameter int unsigned C_DEPTH      = 1024,
    parameter logic [31:0] C_BASE_ADDR  = 32'h0,
    parameter int unsigned C_PROT_WORDS = 0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic        treqready_o,
    input  logic        treqvalid_i,
    input  logic [1:0]  treqhpl_i,
    input  logic [31:0] treqaddr_i,
    input  logic        treqwrite_i,
    input  logic [3:0]  treqbe_i,
    input  logic [31:0] treqdata_i,
    input  logic        trspready_i,
    output logic        trspvalid_o,
    output logic        trsprerr_o,
    output logic        trspwerr_o,
    output logic [31:0] trspdata_o
);

    localparam int AW = $clog2(C_DEPTH);

    logic [31:0] mem [C_DEPTH];
    logic [31:0] idx;
    logic        above_base;
    logic        prot_idx;
    logic        in_range;
    logic        prot_hit;

    logic        acc;
    logic        pop;
    logic        fifo_push;
    logic        fifo_pop;
    logic [1:0]  fifo_cnt;
    logic [1:0]  occ;

    logic        st_vld;
    logic        st_load;
    logic        st_rerr;
    logic        st_werr;
    logic [31:0] rd_q;
    rsp_t        st_rsp;
    rsp_t        fifo_head;
    rsp_t        rsp;

    assign idx = (treqaddr_i - C_BASE_ADDR) >> 2;

    // Constant-range compares are split out so a zero base / zero protected region folds away cleanly.
    generate
        if (C_BASE_ADDR == 32'd0) begin : g_nobase
            assign above_base = 1'b1;
        end else begin : g_base
            assign above_base = (treqaddr_i >= C_BASE_ADDR);
        end
        if (C_PROT_WORDS == 0) begin : g_noprot
            assign prot_idx = 1'b0;
        end else begin : g_prot
            assign prot_idx = (idx < C_PROT_WORDS);
        end
    endgenerate

    assign in_range = above_base && (idx < C_DEPTH);
    assign prot_hit = prot_idx && (treqhpl_i == 2'b00);

    assign occ         = {1'b0, st_vld} + fifo_cnt;
    assign treqready_o = (occ < 2'd2);
    assign acc         = treqvalid_i & treqready_o;
    assign trspvalid_o = st_vld | (fifo_cnt != 2'd0);
    assign pop         = trspvalid_o & trspready_i;
    assign fifo_push   = st_vld & ~(pop & (fifo_cnt == 2'd0));
    assign fifo_pop    = pop & (fifo_cnt != 2'd0);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            st_vld  <= 1'b0;
            st_load <= 1'b0;
            st_rerr <= 1'b0;
            st_werr <= 1'b0;
        end else begin
            st_vld <= acc;
            if (acc) begin
                st_load <= ~treqwrite_i;
                st_rerr <= ~treqwrite_i & ~in_range;
                st_werr <= treqwrite_i & (~in_range | prot_hit);
            end
        end
    end

    // RAM is never reset, so accepted stores survive a reset.
    always_ff @(posedge clk_i) begin
        if (acc && in_range) begin
            if (treqwrite_i) begin
                if (!prot_hit) begin
                    for (int b = 0; b < 4; b++) begin
                        if (treqbe_i[b]) mem[idx[AW-1:0]][8*b +: 8] <= treqdata_i[8*b +: 8];
                    end
                end
            end else begin
                rd_q <= mem[idx[AW-1:0]];
            end
        end
    end

    assign st_rsp = '{rerr: st_rerr, werr: st_werr,
                      data: (st_load && !st_rerr) ? rd_q : 32'd0};

    data_ram_rsp_fifo u_rsp_fifo (
        .clk   (clk_i),
        .rst   (reset_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (st_rsp),
        .dout  (fifo_head),
        .count (fifo_cnt)
    );

    assign rsp        = (fifo_cnt != 2'd0) ? fifo_head : st_rsp;
    assign trsprerr_o = trspvalid_o & rsp.rerr;
    assign trspwerr_o = trspvalid_o & rsp.werr;
    assign trspdata_o = trspvalid_o ? rsp.data : 32'd0;

endmodule
